// File: rtl/fetch_unit_pkg.sv
// Shared widths, state encodings and constants for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int unsigned ADDR_BUS = 32;
   localparam int unsigned DATA_BUS = 32;
   localparam int unsigned PC_INC   = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry pc+inst holding register; clear wins over load.
module fetch_hold_buf
   import fetch_unit_pkg::*;
#(
   parameter int unsigned AW = ADDR_BUS,
   parameter int unsigned DW = DATA_BUS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          clear,
   input  logic [AW-1:0] pc_in,
   input  logic [DW-1:0] inst_in,
   output logic          valid,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] inst
);

   logic          valid_q, valid_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] inst_q, inst_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         inst_d  = inst_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign inst  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, stall/redirect aware.
// Optional FETCH_ALIGN_CHECK_EN adds fetch_addr_err and blocks misaligned requests.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH = ADDR_BUS,
   parameter int unsigned          DATA_WIDTH = DATA_BUS,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic                  fetch_addr_err,
`endif
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] inst_out,
   output logic                  bubble_out
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  kill_q, kill_d;

   logic                  misaligned_c;
   logic                  req_c;
   logic                  hb_load, hb_clear, hb_valid;
   logic [ADDR_WIDTH-1:0] hb_pc;
   logic [DATA_WIDTH-1:0] hb_inst;
   logic                  present;
   logic [ADDR_WIDTH-1:0] pres_pc;
   logic [DATA_WIDTH-1:0] pres_inst;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned_c   = (fetch_pc_q[1:0] != 2'b00);
   assign fetch_addr_err = (state_q == S_REQ) && misaligned_c;
`else
   assign misaligned_c   = 1'b0;
`endif

   assign req_c = (state_q == S_REQ) && !misaligned_c;

   fetch_hold_buf #(
      .AW (ADDR_WIDTH),
      .DW (DATA_WIDTH)
   ) u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (hb_load),
      .clear   (hb_clear),
      .pc_in   (req_pc_q),
      .inst_in (imem_rdata),
      .valid   (hb_valid),
      .pc      (hb_pc),
      .inst    (hb_inst)
   );

   // Next-state, PC and presentation; redirect overrides everything at the end.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      kill_d     = kill_q;
      hb_load    = 1'b0;
      hb_clear   = 1'b0;
      present    = 1'b0;
      pres_pc    = '0;
      pres_inst  = '0;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (req_c && imem_gnt) begin
               state_d    = S_WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_INC);
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else if (!stall) begin
                  present   = 1'b1;
                  pres_pc   = req_pc_q;
                  pres_inst = imem_rdata;
                  state_d   = S_REQ;
               end else begin
                  hb_load = 1'b1;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            present   = hb_valid;
            pres_pc   = hb_pc;
            pres_inst = hb_inst;
            if (!stall) begin
               hb_clear = 1'b1;
               state_d  = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         hb_load    = 1'b0;
         hb_clear   = 1'b1;
         present    = 1'b0;
         pres_pc    = '0;
         pres_inst  = '0;
         if (state_q == S_WAIT && !imem_rvalid) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
         end else if (state_q == S_REQ && req_c && imem_gnt) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
         end else begin
            kill_d  = 1'b0;
            state_d = S_REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
      end
   end

   assign imem_req   = req_c;
   assign imem_addr  = fetch_pc_q;
   assign pc_out     = present ? pres_pc : '0;
   assign inst_out   = present ? pres_inst : '0;
   assign bubble_out = !present;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequence with literal expectations, then randomized
// stall/grant/latency/redirect traffic checked against an in-order instruction-stream model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        bubble_out;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_addr_err;
`endif

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
`ifdef FETCH_ALIGN_CHECK_EN
      .fetch_addr_err (fetch_addr_err),
`endif
      .pc_out      (pc_out),
      .inst_out    (inst_out),
      .bubble_out  (bubble_out)
   );

   int total = 0;
   int bad   = 0;

   // Memory contents: a distinct word per address.
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference state: next instruction address the consumer must see, next address
   // memory must be asked for, and the single in-flight response.
   logic [31:0] exp_pc, exp_req;
   logic        pend_valid;
   int          pend_cnt;
   logic [31:0] pend_addr;
   int          consumed, idle, max_idle;

   logic        o_req, o_bub;
   logic [31:0] o_addr, o_pc, o_inst;

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic gn, input int lat);
      @(negedge clk);
      rst         = 1'b0;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_gnt    = gn;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend_valid) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(pend_addr);
            pend_valid  = 1'b0;
         end
      end
      #2;
      o_req  = imem_req;
      o_addr = imem_addr;
      o_bub  = bubble_out;
      o_pc   = pc_out;
      o_inst = inst_out;

      if (o_bub) begin
         chk("bubble_zero", {8'h0, o_pc, o_inst}, 72'h0);
      end else begin
         chk("inst_data", {40'h0, o_inst}, {40'h0, memfn(o_pc)});
         chk("pc_order", {40'h0, o_pc}, {40'h0, exp_pc});
         chk("no_req_while_valid", {71'h0, o_req}, 72'h0);
      end
      if (rd) chk("redirect_bubble", {71'h0, o_bub}, 72'h1);

      if (o_req && gn) begin
         chk("one_outstanding", {71'h0, pend_valid}, 72'h0);
         chk("req_addr", {40'h0, o_addr}, {40'h0, exp_req});
         exp_req    = o_addr + 32'd4;
         pend_valid = 1'b1;
         pend_cnt   = lat;
         pend_addr  = o_addr;
      end

      idle++;
      if (!o_bub && !st && !rd) begin
         exp_pc = exp_pc + 32'd4;
         consumed++;
         idle = 0;
      end
      if (rd) begin
         exp_pc  = rpc;
         exp_req = rpc;
         idle    = 0;
      end
      if (idle > max_idle) max_idle = idle;
   endtask

   // Directed expectation of {req, addr-if-req, bubble, pc} after a step.
   task automatic dexp(input string name, input logic r, input logic [31:0] a,
                       input logic b, input logic [31:0] p);
      chk(name, {6'h0, o_req, (o_req ? o_addr : 32'h0), o_bub, o_pc},
                {6'h0, r, a, b, p});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      pend_valid = 1'b0; pend_cnt = 0; pend_addr = '0;
      exp_pc = 32'h0; exp_req = 32'h0;
      consumed = 0; idle = 0; max_idle = 0;
      o_req = 1'b0; o_bub = 1'b1; o_addr = '0; o_pc = '0; o_inst = '0;

      repeat (2) @(negedge clk);
      #2;
      chk("reset_outputs", {38'h0, imem_req, bubble_out, pc_out}, {38'h0, 1'b0, 1'b1, 32'h0});
      chk("reset_inst", {40'h0, inst_out}, 72'h0);

      // Straight-line fetch, then a 3-cycle stall while the 0x4 response arrives.
      step(0, 0, 0, 1, 1); dexp("c0_idle",   0, 32'h0,   1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c1_req0",   1, 32'h0,   1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c2_pres0",  0, 32'h0,   0, 32'h0);
      chk("c2_inst0", {40'h0, o_inst}, {40'h0, 32'h5A5A_A5A5});
      step(0, 0, 0, 1, 1); dexp("c3_req4",   1, 32'h4,   1, 32'h0);
      step(1, 0, 0, 1, 1); dexp("c4_load",   0, 32'h0,   1, 32'h0);
      step(1, 0, 0, 1, 1); dexp("c5_hold",   0, 32'h0,   0, 32'h4);
      step(1, 0, 0, 1, 1); dexp("c6_hold",   0, 32'h0,   0, 32'h4);
      step(0, 0, 0, 1, 1); dexp("c7_release",0, 32'h0,   0, 32'h4);
      // Request 0x8 with slow response, redirected before it returns.
      step(0, 0, 0, 1, 3); dexp("c8_req8",   1, 32'h8,   1, 32'h0);
      step(0, 1, 32'h100, 0, 1); dexp("c9_redir", 0, 32'h0, 1, 32'h0);
      step(0, 0, 0, 0, 1); dexp("c10_wait",  0, 32'h0,   1, 32'h0);
      step(0, 0, 0, 0, 1); dexp("c11_drop",  0, 32'h0,   1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c12_req100",1, 32'h100, 1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c13_pres100",0, 32'h0,  0, 32'h100);
      // Redirect while holding under stall.
      step(0, 0, 0, 1, 1); dexp("c14_req104",1, 32'h104, 1, 32'h0);
      step(1, 0, 0, 1, 1); dexp("c15_load",  0, 32'h0,   1, 32'h0);
      step(1, 0, 0, 1, 1); dexp("c16_hold",  0, 32'h0,   0, 32'h104);
      step(1, 1, 32'h200, 1, 1); dexp("c17_redir_hold", 0, 32'h0, 1, 32'h0);
      step(0, 0, 0, 0, 1); dexp("c18_req200",1, 32'h200, 1, 32'h0);
      // PC wrap at the top of the address space.
      step(0, 1, 32'hFFFF_FFFC, 0, 1); dexp("c19_redir", 1, 32'h200, 1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c20_reqtop",1, 32'hFFFF_FFFC, 1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c21_prestop",0, 32'h0,  0, 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 1); dexp("c22_wrap",  1, 32'h0,   1, 32'h0);
      step(0, 0, 0, 1, 1); dexp("c23_pres0", 0, 32'h0,   0, 32'h0);

      // Randomized traffic.
      max_idle = 0;
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         logic        st, rd, gn;
         logic [31:0] tgt;
         st  = ($urandom_range(0, 99) < 30);
         gn  = ($urandom_range(0, 99) < 70);
         rd  = ($urandom_range(0, 99) < 4);
         tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                          : ($urandom & 32'h0000_3FFC);
         step(st, rd, tgt, gn, int'($urandom_range(1, 3)));
      end
      chk("progress", {40'h0, 32'(consumed >= 100)}, {40'h0, 32'h1});
      chk("no_starvation", {40'h0, 32'(max_idle <= 80)}, {40'h0, 32'h1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
